// File: rtl/alu_x_pkg.sv
// Shared definitions for the ALU execution unit: opcode encodings and the
// handshake FSM state type.
package alu_x_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;
    localparam logic [2:0] OP_NOP = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_DIV = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/alu_muldiv_x.sv
// Iterative engine shared by MUL (shift-add) and DIV (restoring), one bit per
// cycle. last is high during the final iteration; *_nxt carry its result.
module alu_muldiv_x #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] lo_nxt,
    output logic [WIDTH-1:0] hi_nxt
);

    localparam int CW = $clog2(WIDTH);

    logic             run_q, run_d;
    logic             mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH-1:0] div_rem;
    logic             div_ge;

    // mode 0: hi accumulates, lo holds the multiplier shifting out LSB-first.
    // mode 1: hi is the partial remainder, lo shifts dividend out / quotient in.
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        div_sh  = {hi_q, lo_q[WIDTH-1]};
        div_ge  = div_sh >= {1'b0, opb_q};
        div_rem = div_sh[WIDTH-1:0] - opb_q;
        last    = run_q && (cnt_q == CW'(WIDTH-1));

        run_d  = run_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        opb_d  = opb_q;
        if (start) begin
            run_d  = 1'b1;
            mode_d = mode;
            cnt_d  = '0;
            hi_d   = '0;
            lo_d   = a;
            opb_d  = b;
        end else if (run_q) begin
            if (!mode_q) begin
                hi_d = mul_sum[WIDTH:1];
                lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end else begin
                hi_d = div_ge ? div_rem : div_sh[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], div_ge};
            end
            if (last) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        lo_nxt = lo_d;
        hi_nxt = hi_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q  <= 1'b0;
            mode_q <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opb_q  <= '0;
        end else begin
            run_q  <= run_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opb_q  <= opb_d;
        end
    end

endmodule

// File: rtl/alu_exec_x.sv
// ALU execution unit: valid/ready front end, single-cycle datapath, and an
// iterative MUL/DIV engine. Results are held in DONE until OUT_READY.
module alu_exec_x
    import alu_x_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] RESULT_HI,
    output logic             ZERO,
    output logic             DIV_BY_ZERO,
    output logic [1:0]       DBG_STATE
);

    // Handshake: a transfer happens on a rising edge where valid & ready;
    // the source holds its payload until then, the sink accepts at most one
    // transfer per edge. In and out never transfer on the same edge.

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             eng_start;
    logic             eng_mode;
    logic             eng_last;
    logic [WIDTH-1:0] eng_lo;
    logic [WIDTH-1:0] eng_hi;
    logic [WIDTH-1:0] alu_res;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (OP == OP_MUL)                  state_d = ST_MUL;
                    else if (OP == OP_DIV && B != '0)  state_d = ST_DIV;
                    else                               state_d = ST_DONE;
                end
            end
            ST_MUL, ST_DIV: if (eng_last) state_d = ST_DONE;
            ST_DONE:        if (OUT_READY) state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        IN_READY  = (state_q == ST_IDLE);
        OUT_VALID = (state_q == ST_DONE);
        DBG_STATE = state_q;
        accept    = IN_VALID && IN_READY;
        eng_mode  = (OP == OP_DIV);
        eng_start = accept && ((OP == OP_MUL) || (OP == OP_DIV && B != '0));
    end

    // Division by zero lands here too: all-ones quotient, dividend as remainder.
    always_comb begin
        case (OP)
            OP_ADD:  alu_res = A + B;
            OP_SUB:  alu_res = A - B;
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            OP_NOP:  alu_res = '0;
            default: alu_res = '1;
        endcase
    end

    always_comb begin
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        dbz_d       = dbz_q;
        if (accept) begin
            zero_d = 1'b0;
            dbz_d  = 1'b0;
            if (!eng_start) begin
                result_d    = alu_res;
                result_hi_d = (OP == OP_DIV) ? A : '0;
                zero_d      = (alu_res == '0);
                dbz_d       = (OP == OP_DIV);
            end
        end else if (eng_last && (state_q == ST_MUL || state_q == ST_DIV)) begin
            result_d    = eng_lo;
            result_hi_d = eng_hi;
            zero_d      = (eng_lo == '0);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            dbz_q       <= dbz_d;
        end
    end

    assign RESULT      = result_q;
    assign RESULT_HI   = result_hi_q;
    assign ZERO        = zero_q;
    assign DIV_BY_ZERO = dbz_q;

    alu_muldiv_x #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (CLK),
        .rst    (RST),
        .start  (eng_start),
        .mode   (eng_mode),
        .a      (A),
        .b      (B),
        .last   (eng_last),
        .lo_nxt (eng_lo),
        .hi_nxt (eng_hi)
    );

endmodule

// File: tb/tb_alu_exec_x.sv
// Self-checking bench for alu_exec_x: directed corner cases, backpressure,
// mid-operation reset, then randomized ops against a behavioural model.
module tb_alu_exec_x;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST;
  logic         IN_VALID;
  logic         IN_READY;
  logic [2:0]   OP;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] RESULT;
  logic [W-1:0] RESULT_HI;
  logic         ZERO;
  logic         DIV_BY_ZERO;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  alu_exec_x #(.WIDTH(W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .OP          (OP),
    .A           (A),
    .B           (B),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .RESULT      (RESULT),
    .RESULT_HI   (RESULT_HI),
    .ZERO        (ZERO),
    .DIV_BY_ZERO (DIV_BY_ZERO),
    .DBG_STATE   (dbg_state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the operands.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic [W-1:0] rh, output logic dz);
    logic [2*W-1:0] p;
    rh = '0;
    dz = 1'b0;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      3'd5: r = '0;
      3'd6: begin
        p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r  = p[W-1:0];
        rh = p[2*W-1:W];
      end
      default: begin
        if (b == '0) begin
          r  = '1;
          rh = a;
          dz = 1'b1;
        end else begin
          r  = a / b;
          rh = a % b;
        end
      end
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall);
    logic [W-1:0] er, eh;
    logic         ed;
    int           lat;
    int           exp_lat;
    model(op, a, b, er, eh, ed);
    exp_q.push_back(er);
    exp_q.push_back(eh);
    exp_lat = (op == 3'd6 || (op == 3'd7 && b != '0)) ? W + 1 : 1;

    @(negedge CLK);
    check("in_ready_idle", IN_READY, 1);
    IN_VALID = 1'b1;
    OP = op;
    A = a;
    B = b;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    OP = 3'($urandom_range(0, 7));
    A = $urandom;
    B = $urandom;

    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
      if (!OUT_VALID) check("in_ready_busy", IN_READY, 0);
    end while (!OUT_VALID && lat < 200);
    check("latency", lat, exp_lat);

    er = exp_q.pop_front();
    eh = exp_q.pop_front();
    IN_VALID = 1'b1;
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) @(negedge CLK);
      check("out_valid_hold", OUT_VALID, 1);
      check("in_ready_done", IN_READY, 0);
      if (s == 0 || s == stall) begin
        check("result", RESULT, er);
        check("result_hi", RESULT_HI, eh);
        check("zero", ZERO, (er == '0));
        check("div_by_zero", DIV_BY_ZERO, ed);
      end
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    OUT_READY = 1'b0;
    @(negedge CLK);
    check("out_valid_clear", OUT_VALID, 0);
    check("in_ready_back", IN_READY, 1);
    check("result_kept", RESULT, er);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, OUT_VALID, 0);
    check({tag, "_result"}, RESULT, 0);
    check({tag, "_result_hi"}, RESULT_HI, 0);
    check({tag, "_zero"}, ZERO, 0);
    check({tag, "_dbz"}, DIV_BY_ZERO, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   rop;
    bit           rose;
    RST = 1'b1;
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    OP = '0;
    A = '0;
    B = '0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RST = 1'b0;
    @(negedge CLK);
    check("reset_in_ready", IN_READY, 1);
    check_reset_outputs("post_reset");

    run_op(3'd0, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(3'd4, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(3'd4, 32'd1, 32'hFFFF_FFFF, 0);
    run_op(3'd1, 32'd5, 32'd7, 0);
    run_op(3'd6, 32'hFFFF_FFFF, 32'd2, 0);
    run_op(3'd7, 32'd100, 32'd7, 0);
    run_op(3'd7, 32'd5, 32'd0, 0);
    run_op(3'd5, 32'h1234_5678, 32'h9ABC_DEF0, 1);
    run_op(3'd6, 32'd7, 32'd6, 5);
    run_op(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd7, 32'd3, 32'd10, 0);

    // Reset pulse ten cycles into a MUL: no result may ever appear.
    @(negedge CLK);
    IN_VALID = 1'b1;
    OP = 3'd6;
    A = 32'd123;
    B = 32'd456;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    repeat (10) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_reset_outputs("mid_mul_reset");
    RST = 1'b0;
    @(negedge CLK);
    check("mid_mul_in_ready", IN_READY, 1);
    check_reset_outputs("mid_mul_release");
    rose = 1'b0;
    repeat (W + 5) begin
      @(negedge CLK);
      if (OUT_VALID) rose = 1'b1;
    end
    check("no_partial_result", rose, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = '0;
        1: ra = '1;
        2: rb = 32'($urandom_range(0, 15));
        3: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      if (rop == 3'd7 && $urandom_range(0, 4) == 0) rb = '0;
      run_op(rop, ra, rb, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
